// File: rtl/msp430_pkg.sv
// rtl/msp430_pkg.sv - shared constants and helpers for the MSP430 register file
package msp430_pkg;

    typedef logic [15:0] word_t;

    localparam logic [3:0] REG_PC  = 4'd0;
    localparam logic [3:0] REG_SP  = 4'd1;
    localparam logic [3:0] REG_SR  = 4'd2;
    localparam logic [3:0] REG_CG2 = 4'd3;

    typedef enum logic [1:0] {
        AS_REG = 2'b00,
        AS_IDX = 2'b01,
        AS_IND = 2'b10,
        AS_INC = 2'b11
    } as_mode_e;

    localparam word_t CG_ZERO   = 16'h0000;
    localparam word_t CG_ONE    = 16'h0001;
    localparam word_t CG_TWO    = 16'h0002;
    localparam word_t CG_FOUR   = 16'h0004;
    localparam word_t CG_EIGHT  = 16'h0008;
    localparam word_t CG_MINUS1 = 16'hFFFF;

    // PC and SP are word pointers, so bit0 is never stored
    function automatic word_t align_word(input word_t v);
        return {v[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/msp430_const_gen.sv
// rtl/msp430_const_gen.sv - constant generator on R2/R3 for the source read port
import msp430_pkg::*;

module msp430_const_gen (
    input  logic [3:0]  i_sa,
    input  logic [1:0]  i_as,
    input  logic [15:0] i_sr,
    output logic        o_is_const,
    output logic [15:0] o_value
);

    as_mode_e w_mode;

    assign w_mode = as_mode_e'(i_as);

    // R2 in register mode still yields SR, so this block owns every R2/R3 read
    always_comb begin
        o_is_const = 1'b0;
        o_value    = CG_ZERO;
        if (i_sa == REG_SR) begin
            o_is_const = 1'b1;
            case (w_mode)
                AS_REG: o_value = i_sr;
                AS_IDX: o_value = CG_ZERO;
                AS_IND: o_value = CG_FOUR;
                AS_INC: o_value = CG_EIGHT;
            endcase
        end else if (i_sa == REG_CG2) begin
            o_is_const = 1'b1;
            case (w_mode)
                AS_REG: o_value = CG_ZERO;
                AS_IDX: o_value = CG_ONE;
                AS_IND: o_value = CG_TWO;
                AS_INC: o_value = CG_MINUS1;
            endcase
        end
    end

endmodule

// File: rtl/msp430_reg_file.sv
// rtl/msp430_reg_file.sv - MSP430 sixteen-entry register file with PC/SP/SR side ports
import msp430_pkg::*;

module msp430_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] RST_VEC,
    input  logic        RW,
    input  logic [3:0]  DA,
    input  logic [3:0]  SA,
    input  logic [1:0]  As,
    input  logic [15:0] Din,
    input  logic [15:0] reg_PC_in,
    input  logic [15:0] reg_SP_in,
    input  logic [15:0] reg_SR_in,
    output logic [15:0] Dout,
    output logic [15:0] Sout,
    output logic [15:0] reg_PC_out,
    output logic [15:0] reg_SP_out,
    output logic [15:0] reg_SR_out
);

    logic [15:0] r_pc;
    logic [15:0] r_sp;
    logic [15:0] r_sr;
    logic [15:0] r_gpr [0:11];

    logic        w_pc_wr;
    logic        w_sp_wr;
    logic        w_sr_wr;
    logic [15:0] w_regs [0:15];
    logic        w_is_const;
    logic [15:0] w_cg_value;

    assign w_pc_wr = RW && (DA == REG_PC);
    assign w_sp_wr = RW && (DA == REG_SP);
    assign w_sr_wr = RW && (DA == REG_SR);

    // Datapath writes win over the fetch/stack/status update paths
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= align_word(RST_VEC);
            r_sp <= CG_ZERO;
            r_sr <= CG_ZERO;
            for (int i = 0; i < 12; i++) begin
                r_gpr[i] <= CG_ZERO;
            end
        end else begin
            r_pc <= align_word(w_pc_wr ? Din : reg_PC_in);
            r_sp <= align_word(w_sp_wr ? Din : reg_SP_in);
            r_sr <= w_sr_wr ? Din : reg_SR_in;
            for (int i = 4; i < 16; i++) begin
                if (RW && (DA == 4'(i))) begin
                    r_gpr[i-4] <= Din;
                end
            end
        end
    end

    // R3 has no storage and always reads as zero on the destination port
    always_comb begin
        w_regs[0] = r_pc;
        w_regs[1] = r_sp;
        w_regs[2] = r_sr;
        w_regs[3] = CG_ZERO;
        for (int i = 0; i < 12; i++) begin
            w_regs[i+4] = r_gpr[i];
        end
    end

    msp430_const_gen u_const_gen (
        .i_sa       (SA),
        .i_as       (As),
        .i_sr       (r_sr),
        .o_is_const (w_is_const),
        .o_value    (w_cg_value)
    );

    assign Dout       = w_regs[DA];
    assign Sout       = w_is_const ? w_cg_value : w_regs[SA];
    assign reg_PC_out = r_pc;
    assign reg_SP_out = r_sp;
    assign reg_SR_out = r_sr;

endmodule

// File: tb/tb_msp430_reg_file.sv
// tb/tb_msp430_reg_file.sv - self-checking bench for msp430_reg_file
module tb_msp430_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] RST_VEC;
    logic        RW;
    logic [3:0]  DA;
    logic [3:0]  SA;
    logic [1:0]  As;
    logic [15:0] Din;
    logic [15:0] reg_PC_in;
    logic [15:0] reg_SP_in;
    logic [15:0] reg_SR_in;
    logic [15:0] Dout;
    logic [15:0] Sout;
    logic [15:0] reg_PC_out;
    logic [15:0] reg_SP_out;
    logic [15:0] reg_SR_out;

    always #5 clk = ~clk;

    msp430_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .RST_VEC    (RST_VEC),
        .RW         (RW),
        .DA         (DA),
        .SA         (SA),
        .As         (As),
        .Din        (Din),
        .reg_PC_in  (reg_PC_in),
        .reg_SP_in  (reg_SP_in),
        .reg_SR_in  (reg_SR_in),
        .Dout       (Dout),
        .Sout       (Sout),
        .reg_PC_out (reg_PC_out),
        .reg_SP_out (reg_SP_out),
        .reg_SR_out (reg_SR_out)
    );

    typedef struct {
        logic        rw;
        logic [3:0]  da;
        logic [3:0]  sa;
        logic [1:0]  as_m;
        logic [15:0] din;
        logic [15:0] pc_in;
        logic [15:0] sp_in;
        logic [15:0] sr_in;
        logic [15:0] e_pc;
        logic [15:0] e_sp;
        logic [15:0] e_sr;
        logic [15:0] e_dout;
        logic [15:0] e_sout;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mdl [16];
    vec_t        vecs [17];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] a);
        return (a == 4'd3) ? 16'h0000 : mdl[a];
    endfunction

    function automatic logic [15:0] m_sout(input logic [3:0] a, input logic [1:0] m);
        logic [15:0] cg_r2 [4];
        logic [15:0] cg_r3 [4];
        cg_r2 = '{mdl[2], 16'h0000, 16'h0004, 16'h0008};
        cg_r3 = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
        if (a == 4'd2) return cg_r2[m];
        if (a == 4'd3) return cg_r3[m];
        return mdl[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            foreach (mdl[i]) mdl[i] = 16'h0000;
            mdl[0] = RST_VEC & 16'hFFFE;
        end else begin
            mdl[0] = ((RW && DA == 4'd0) ? Din : reg_PC_in) & 16'hFFFE;
            mdl[1] = ((RW && DA == 4'd1) ? Din : reg_SP_in) & 16'hFFFE;
            mdl[2] = (RW && DA == 4'd2) ? Din : reg_SR_in;
            if (RW && DA >= 4'd4) mdl[DA] = Din;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        foreach (mdl[i]) mdl[i] = 16'h0000;
        vecs[0]  = '{1'b0, 4'd4,  4'd4,  2'd0, 16'h0000, 16'hC002, 16'h0000, 16'h0000, 16'hC002, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 4'd4,  4'd4,  2'd0, 16'h0000, 16'hC004, 16'h0000, 16'h0000, 16'hC004, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 4'd4,  4'd4,  2'd0, 16'h0000, 16'hC003, 16'h0000, 16'h0000, 16'hC002, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 4'd4,  4'd4,  2'd3, 16'hF000, 16'hC004, 16'h0000, 16'h0000, 16'hC004, 16'h0000, 16'h0000, 16'hF000, 16'hF000};
        vecs[4]  = '{1'b1, 4'd1,  4'd1,  2'd0, 16'h0300, 16'hC006, 16'h0200, 16'h0000, 16'hC006, 16'h0300, 16'h0000, 16'h0300, 16'h0300};
        vecs[5]  = '{1'b1, 4'd2,  4'd2,  2'd0, 16'h0005, 16'hC008, 16'h0300, 16'hFFFF, 16'hC008, 16'h0300, 16'h0005, 16'h0005, 16'h0005};
        vecs[6]  = '{1'b0, 4'd2,  4'd2,  2'd0, 16'h0000, 16'hC00A, 16'h0300, 16'hFFFF, 16'hC00A, 16'h0300, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[7]  = '{1'b0, 4'd2,  4'd2,  2'd1, 16'h0000, 16'hC00C, 16'h0300, 16'hFFFF, 16'hC00C, 16'h0300, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[8]  = '{1'b0, 4'd2,  4'd2,  2'd2, 16'h0000, 16'hC00E, 16'h0300, 16'hFFFF, 16'hC00E, 16'h0300, 16'hFFFF, 16'hFFFF, 16'h0004};
        vecs[9]  = '{1'b0, 4'd2,  4'd2,  2'd3, 16'h0000, 16'hC010, 16'h0300, 16'hFFFF, 16'hC010, 16'h0300, 16'hFFFF, 16'hFFFF, 16'h0008};
        vecs[10] = '{1'b0, 4'd2,  4'd3,  2'd0, 16'h0000, 16'hC012, 16'h0300, 16'hFFFF, 16'hC012, 16'h0300, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[11] = '{1'b0, 4'd2,  4'd3,  2'd1, 16'h0000, 16'hC014, 16'h0300, 16'hFFFF, 16'hC014, 16'h0300, 16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[12] = '{1'b0, 4'd2,  4'd3,  2'd2, 16'h0000, 16'hC016, 16'h0300, 16'hFFFF, 16'hC016, 16'h0300, 16'hFFFF, 16'hFFFF, 16'h0002};
        vecs[13] = '{1'b0, 4'd2,  4'd3,  2'd3, 16'h0000, 16'hC018, 16'h0300, 16'hFFFF, 16'hC018, 16'h0300, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[14] = '{1'b1, 4'd3,  4'd3,  2'd0, 16'h1234, 16'hC01A, 16'h0300, 16'hFFFF, 16'hC01A, 16'h0300, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[15] = '{1'b1, 4'd0,  4'd4,  2'd3, 16'h1235, 16'hC000, 16'h0300, 16'hFFFF, 16'h1234, 16'h0300, 16'hFFFF, 16'h1234, 16'hF000};
        vecs[16] = '{1'b1, 4'd15, 4'd15, 2'd1, 16'hABCD, 16'h1236, 16'h0301, 16'hFFFF, 16'h1236, 16'h0300, 16'hFFFF, 16'hABCD, 16'hABCD};

        rst = 1'b1; RST_VEC = 16'hC000; RW = 1'b0; DA = 4'd4; SA = 4'd4; As = 2'd0;
        Din = 16'h0000; reg_PC_in = 16'h0000; reg_SP_in = 16'h0000; reg_SR_in = 16'h0000;
        tick();
        check("reset pc", reg_PC_out, 16'hC000);
        check("reset sp", reg_SP_out, 16'h0000);
        check("reset sr", reg_SR_out, 16'h0000);
        check("reset dout r4", Dout, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            RW = vecs[i].rw; DA = vecs[i].da; SA = vecs[i].sa; As = vecs[i].as_m;
            Din = vecs[i].din; reg_PC_in = vecs[i].pc_in;
            reg_SP_in = vecs[i].sp_in; reg_SR_in = vecs[i].sr_in;
            tick();
            check($sformatf("v%0d pc", i), reg_PC_out, vecs[i].e_pc);
            check($sformatf("v%0d sp", i), reg_SP_out, vecs[i].e_sp);
            check($sformatf("v%0d sr", i), reg_SR_out, vecs[i].e_sr);
            check($sformatf("v%0d dout", i), Dout, vecs[i].e_dout);
            check($sformatf("v%0d sout", i), Sout, vecs[i].e_sout);
        end

        // write to R5 must not be visible before the edge
        RW = 1'b1; DA = 4'd5; SA = 4'd5; As = 2'd3; Din = 16'h5555;
        reg_PC_in = 16'h2000; reg_SP_in = 16'h0400; reg_SR_in = 16'h0100;
        #1;
        check("no bypass dout", Dout, 16'h0000);
        check("no bypass sout", Sout, 16'h0000);
        tick();
        check("r5 written dout", Dout, 16'h5555);
        check("r5 written sout", Sout, 16'h5555);

        // reset during a pending write discards it
        rst = 1'b1; RST_VEC = 16'h8001; RW = 1'b1; DA = 4'd6; Din = 16'h6666;
        tick();
        rst = 1'b0; RW = 1'b0;
        check("midrst pc", reg_PC_out, 16'h8000);
        check("midrst sp", reg_SP_out, 16'h0000);
        check("midrst sr", reg_SR_out, 16'h0000);
        check("midrst r6", Dout, 16'h0000);
        SA = 4'd5; As = 2'd0; DA = 4'd15;
        #1;
        check("midrst r5", Sout, 16'h0000);
        check("midrst r15", Dout, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 31) == 0);
            RST_VEC   = 16'($urandom);
            RW        = 1'($urandom);
            DA        = 4'($urandom);
            SA        = 4'($urandom);
            As        = 2'($urandom);
            Din       = 16'($urandom);
            reg_PC_in = 16'($urandom);
            reg_SP_in = 16'($urandom);
            reg_SR_in = 16'($urandom);
            #1;
            check($sformatf("rnd%0d dout", i), Dout, m_read(DA));
            check($sformatf("rnd%0d sout", i), Sout, m_sout(SA, As));
            tick();
            check($sformatf("rnd%0d pc", i), reg_PC_out, mdl[0]);
            check($sformatf("rnd%0d sp", i), reg_SP_out, mdl[1]);
            check($sformatf("rnd%0d sr", i), reg_SR_out, mdl[2]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
